// File: rtl/jk_checker_if.sv
// Signal bundle between a JK trigger under observation and its checker.
// The master side drives the observed trigger signals; the slave side is the checker.
interface jk_checker_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             J;
    logic             K;
    logic             q;
    logic             qn;
    logic             mismatch;
    logic             comp_err;
    logic             fault;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] tog_cnt;
    logic [1:0]       state;

    modport master (
        output en, clr, J, K, q, qn,
        input  mismatch, comp_err, fault, err_cnt, tog_cnt, state
    );

    modport slave (
        input  en, clr, J, K, q, qn,
        output mismatch, comp_err, fault, err_cnt, tog_cnt, state
    );
endinterface

// File: rtl/jk_checker.sv
// Monitor for a JK trigger: predicts next q from J/K, flags next-state and
// complement errors, and keeps saturating error/toggle counters.
module jk_checker #(
    parameter int unsigned CNT_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    jk_checker_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSync  = 2'd1,
        StCheck = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic             exp_q_q, exp_q_d;
    logic             q_prev_q, q_prev_d;
    logic             mismatch_q, mismatch_d;
    logic             comp_err_q, comp_err_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;

    logic check;
    logic pred;
    logic mis;
    logic cerr;

    always_comb begin
        check = bus.en && (state_q == StCheck);

        unique case ({bus.J, bus.K})
            2'b00:   pred = bus.q;
            2'b01:   pred = 1'b0;
            2'b10:   pred = 1'b1;
            2'b11:   pred = ~bus.q;
            default: pred = bus.q;
        endcase

        mis  = check && (bus.q != exp_q_q);
        cerr = check && (bus.qn == bus.q);

        // Prediction tracks q only; SYNC seeds it without comparing.
        exp_q_d  = exp_q_q;
        q_prev_d = q_prev_q;
        if ((state_q == StSync) || check) begin
            exp_q_d  = pred;
            q_prev_d = bus.q;
        end

        state_d = StIdle;
        if (bus.en) begin
            unique case (state_q)
                StIdle:  state_d = StSync;
                StSync:  state_d = StCheck;
                StCheck: state_d = StCheck;
                default: state_d = StIdle;
            endcase
        end

        mismatch_d = mis && !bus.clr;
        comp_err_d = cerr && !bus.clr;

        fault_d   = fault_q | mis | cerr;
        err_cnt_d = err_cnt_q;
        tog_cnt_d = tog_cnt_q;
        if ((mis || cerr) && (err_cnt_q != CntMax)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        if (check && (bus.q != q_prev_q) && (tog_cnt_q != CntMax)) begin
            tog_cnt_d = tog_cnt_q + 1'b1;
        end
        if (bus.clr) begin
            fault_d   = 1'b0;
            err_cnt_d = '0;
            tog_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            exp_q_q    <= 1'b0;
            q_prev_q   <= 1'b0;
            mismatch_q <= 1'b0;
            comp_err_q <= 1'b0;
            fault_q    <= 1'b0;
            err_cnt_q  <= '0;
            tog_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            exp_q_q    <= exp_q_d;
            q_prev_q   <= q_prev_d;
            mismatch_q <= mismatch_d;
            comp_err_q <= comp_err_d;
            fault_q    <= fault_d;
            err_cnt_q  <= err_cnt_d;
            tog_cnt_q  <= tog_cnt_d;
        end
    end

    assign bus.mismatch = mismatch_q;
    assign bus.comp_err = comp_err_q;
    assign bus.fault    = fault_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.tog_cnt  = tog_cnt_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_jk_checker.sv
// Directed bench for jk_checker: an 8-bit instance and a 2-bit instance see the
// same stimulus; each row lists inputs before an edge and outputs after it.
module tb_jk_checker;
    logic clk;
    logic rst_n;

    jk_checker_if #(.CNT_W(8)) b8 ();
    jk_checker_if #(.CNT_W(2)) b2 ();

    jk_checker #(.CNT_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    jk_checker #(.CNT_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        logic       rst_n, en, clr, j, k, q, qn;
        logic       mis, ce, flt;
        logic [7:0] err, tog;
        logic [1:0] st;
        logic [1:0] s_err;
        logic       s_flt;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic e, logic c, logic j, logic k, logic q,
                                logic qn, logic mi, logic ce, logic fl, logic [7:0] er,
                                logic [7:0] tg, logic [1:0] st, logic [1:0] se, logic sf);
        vec_t v;
        v.rst_n = r;  v.en = e;   v.clr = c;  v.j = j;    v.k = k;   v.q = q;  v.qn = qn;
        v.mis = mi;   v.ce = ce;  v.flt = fl; v.err = er; v.tog = tg; v.st = st;
        v.s_err = se; v.s_flt = sf;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst_n  = v.rst_n;
        b8.en  = v.en;  b8.clr = v.clr; b8.J = v.j; b8.K = v.k; b8.q = v.q; b8.qn = v.qn;
        b2.en  = v.en;  b2.clr = v.clr; b2.J = v.j; b2.K = v.k; b2.q = v.q; b2.qn = v.qn;
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input string name, input int idx, input vec_t v);
        logic [20:0] got8, exp8;
        logic [2:0]  got2, exp2;
        got8 = {b8.mismatch, b8.comp_err, b8.fault, b8.err_cnt, b8.tog_cnt, b8.state};
        exp8 = {v.mis, v.ce, v.flt, v.err, v.tog, v.st};
        got2 = {b2.err_cnt, b2.fault};
        exp2 = {v.s_err, v.s_flt};
        checks++;
        if (got8 !== exp8) begin
            failures++;
            $display("FAIL %s[%0d] {mis,ce,flt,err,tog,st}: got %0b/%0b/%0b/%0d/%0d/%0d want %0b/%0b/%0b/%0d/%0d/%0d",
                     name, idx, b8.mismatch, b8.comp_err, b8.fault, b8.err_cnt, b8.tog_cnt,
                     b8.state, v.mis, v.ce, v.flt, v.err, v.tog, v.st);
        end
        checks++;
        if (got2 !== exp2) begin
            failures++;
            $display("FAIL %s[%0d] narrow {err,flt}: got %0d/%0b want %0d/%0b",
                     name, idx, b2.err_cnt, b2.fault, v.s_err, v.s_flt);
        end
    endtask

    initial begin
        vec_t rv;
        rst_n = 1'b0;
        b8.en = 1'b0; b8.clr = 1'b0; b8.J = 1'b0; b8.K = 1'b0; b8.q = 1'b0; b8.qn = 1'b1;
        b2.en = 1'b0; b2.clr = 1'b0; b2.J = 1'b0; b2.K = 1'b0; b2.q = 1'b0; b2.qn = 1'b1;

        // Hand sequence: two reset cycles, enable and clear also asserted.
        rv = mk(0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 8'd0, 8'd0, 2'd0, 2'd0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(rv);
            check_row("reset", i, rv);
        end

        //         r  en clr J  K  q  qn  mis ce flt err    tog    st    s_err s_flt
        // normal run: JK = 01,10,11,00 twice, trigger starts at q=0
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1,  0, 0, 0, 8'd0, 8'd0, 2'd1, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  0, 0, 0, 8'd0, 8'd0, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 0,  0, 0, 0, 8'd0, 8'd1, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 8'd0, 8'd2, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1,  0, 0, 0, 8'd0, 8'd2, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  0, 0, 0, 8'd0, 8'd2, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 0,  0, 0, 0, 8'd0, 8'd3, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 8'd0, 8'd4, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 8'd0, 8'd4, 2'd2, 2'd0, 0));
        // stuck q: set applied, q stays 0 at the next sample
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  0, 0, 0, 8'd0, 8'd4, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1,  1, 0, 1, 8'd1, 8'd4, 2'd2, 2'd1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1,  0, 0, 1, 8'd1, 8'd4, 2'd2, 2'd1, 1));
        // complement fault: q correct (1) but qn also 1
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  0, 0, 1, 8'd1, 8'd4, 2'd2, 2'd1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1,  0, 1, 1, 8'd2, 8'd5, 2'd2, 2'd2, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0,  0, 0, 1, 8'd2, 8'd5, 2'd2, 2'd2, 1));
        // saturation: set applied six times, q stuck at 0
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  1, 0, 1, 8'd3, 8'd6, 2'd2, 2'd3, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  1, 0, 1, 8'd4, 8'd6, 2'd2, 2'd3, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  1, 0, 1, 8'd5, 8'd6, 2'd2, 2'd3, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  1, 0, 1, 8'd6, 8'd6, 2'd2, 2'd3, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  1, 0, 1, 8'd7, 8'd6, 2'd2, 2'd3, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  1, 0, 1, 8'd8, 8'd6, 2'd2, 2'd3, 1));
        // clear beats a simultaneous error
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 1,  0, 0, 0, 8'd0, 8'd0, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0,  0, 0, 0, 8'd0, 8'd1, 2'd2, 2'd0, 0));
        // drop enable, re-raise: SYNC ignores a bad sample
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 8'd0, 8'd1, 2'd0, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  0, 0, 0, 8'd0, 8'd1, 2'd1, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 8'd0, 8'd1, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1,  0, 0, 0, 8'd0, 8'd1, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0,  1, 0, 1, 8'd1, 8'd2, 2'd2, 2'd1, 1));
        // reset in CHECK, then first pulse two edges after enable is seen
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 8'd0, 8'd0, 2'd0, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 8'd0, 8'd0, 2'd1, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1,  0, 0, 0, 8'd0, 8'd0, 2'd2, 2'd0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1,  1, 0, 1, 8'd1, 8'd1, 2'd2, 2'd1, 1));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            check_row("row", i, tbl[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jk_checker.md
# jk_checker

Synchronous self-checking monitor that sits directly downstream of the JK trigger and consumes its `q`/`qn` outputs alongside the `J`/`K` inputs that drive it. Every cycle it predicts the trigger's next state from the JK truth table. It flags next-state mismatches and `q`/`qn` complement violations, and counts errors and observed toggles. It replaces manual waveform inspection in the lab bench and can be synthesised beside the trigger on the board for LED/7-segment fault reporting.

## Interface
Parameters:
- `CNT_W`, 8: width of the saturating counters `err_cnt` and `tog_cnt`.

Ports:
- `clk`, input, 1: single clock, rising edge. Same clock as the JK trigger.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `en`, input, 1: checking enable. Level-sensitive.
- `clr`, input, 1: synchronous clear of counters and the sticky flag. Does not change state.
- `J`, input, 1: J input as driven to the trigger.
- `K`, input, 1: K input as driven to the trigger.
- `q`, input, 1: trigger output.
- `qn`, input, 1: trigger complementary output.
- `mismatch`, output, 1: one-cycle pulse; observed `q` differs from predicted `q`.
- `comp_err`, output, 1: one-cycle pulse; `qn != ~q` on a checked sample.
- `fault`, output, 1: sticky OR of all `mismatch` and `comp_err` pulses since the last reset or clear.
- `err_cnt`, output, CNT_W: saturating count of cycles with `mismatch` or `comp_err` set (a cycle with both counts 1).
- `tog_cnt`, output, CNT_W: saturating count of observed `q` transitions while in CHECK.
- `state`, output, 2: FSM state encoding: 0 = IDLE, 1 = SYNC, 2 = CHECK.

## Operation
- The checker samples `J`, `K`, `q`, `qn` at every rising edge: the values present just before that edge.
- Prediction from the sampled values: `J`=0,`K`=0 gives old `q`; 0,1 gives 0; 1,0 gives 1; 1,1 gives `~q`. The prediction is stored in `exp_q`.
- FSM:
  - IDLE: no checks, no counting. Goes to SYNC on `en`=1.
  - SYNC: exactly one cycle. Loads `exp_q` and `q_prev` from the sampled inputs; no comparison, because the trigger's power-up state is unknown. Goes to CHECK if `en`=1, otherwise IDLE.
  - CHECK: each edge compares sampled `q` against `exp_q` and checks `qn == ~q`, then reloads `exp_q`. Increments `tog_cnt` when `q != q_prev`. Goes to IDLE on `en`=0.
- `en`=0 in any state: the next state is IDLE, no check occurs at that edge, and counters and `fault` hold.
- Counters saturate at 2^CNT_W−1 with no wrap. `fault` stays set while `err_cnt` is saturated.
- `clr`=1: the counters and `fault` go to 0 at that edge, and the edge's own comparison result is discarded. `clr` wins over increment.
- The complement check does not update `exp_q`: prediction always follows `q`, never `qn`.

## Timing
- Reset (`rst_n`=0 at an edge) sets `state`=IDLE and `mismatch`, `comp_err`, `fault`, `err_cnt`, `tog_cnt`, `exp_q`, `q_prev` all to 0. Reset overrides `en` and `clr`.
- Reset asserted mid-CHECK takes effect at that edge. After release, the checker needs `en` plus one SYNC cycle before any comparison.
- Latency: `J`/`K` applied before edge n, the trigger updates `q` at edge n, and the checker compares that `q` at edge n+1. `mismatch`/`comp_err` are registered at edge n+1, high for exactly one cycle.
- `fault` rises in the same cycle as the first error pulse. `err_cnt` and `tog_cnt` update at the same edge as the pulse.
- Entering from IDLE: the first possible error pulse appears 2 edges after the edge at which `en`=1 is first sampled (SYNC, then CHECK).

## Test plan
- Reset then normal run: `rst_n`=0 for 2 cycles, then `en`=1, correct trigger, stimulus J/K = 01,10,11,00 repeated twice at 100 ns steps (clk period 100 ns). Required: `mismatch`=0 throughout, `fault`=0, `err_cnt`=0, and `tog_cnt` equal to the number of observed `q` transitions (the toggle step always counts one).
- Injected stuck `q`: force `q`=0 while J/K=10 is applied. Required: `mismatch` pulses 1 cycle, one edge after the trigger should have set; `fault`=1; `err_cnt`=1.
- Complement fault: force `qn`=`q`=1 for one sample in CHECK. Required: one-cycle `comp_err`; `err_cnt` incremented by 1; `mismatch`=0.
- Saturation: `CNT_W`=2 with a persistently wrong `q` for 6 cycles. Required: `err_cnt` stops at 3 and `fault` stays 1; then `clr`=1 for one cycle gives `err_cnt`=0 and `fault`=0.
- Enable/reset mid-operation: drop `en` in CHECK. Required: `state`=0 next cycle and counters hold. Re-raise `en`: one SYNC cycle with no pulse even if `q` mismatches. Then `rst_n`=0 in CHECK: all outputs 0 at the next edge.
